// File: rtl/ro_puf_sampler_if.sv
// Bundle of request, PUF-array and result signals between the RO PUF sampler
// and its controller; parameters must match those of the attached sampler.
`timescale 1ns/1ps
interface ro_puf_sampler_if #(
    parameter int N_RO  = 9,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    localparam int SEL_W = $clog2(N_RO);

    logic             start;
    logic [WIN_W-1:0] window;
    logic [CNT_W-1:0] margin;
    logic             ro_in;
    logic [SEL_W-1:0] ro_select;
    logic             ro_en;
    logic             busy;
    logic             valid;
    logic [N_RO-2:0]  response;
    logic [N_RO-2:0]  mask;

    modport master (
        output start, window, margin, ro_in,
        input  ro_select, ro_en, busy, valid, response, mask
    );

    modport slave (
        input  start, window, margin, ro_in,
        output ro_select, ro_en, busy, valid, response, mask
    );
endinterface

// File: rtl/ro_puf_sampler.sv
// Ring-oscillator PUF sampler: counts synchronised edges of each RO over a window
// and compares adjacent counts. Define PUF_MASK_EN to build the reliability mask.
`timescale 1ns/1ps
module ro_puf_sampler #(
    parameter int N_RO  = 9,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    ro_puf_sampler_if.slave bus
);
    localparam int SEL_W = $clog2(N_RO);
    localparam logic [SEL_W-1:0] LAST_RO     = SEL_W'(N_RO - 1);
    localparam logic [SEL_W-1:0] LAST_PAIR   = SEL_W'(N_RO - 2);
    localparam logic [SEL_W-1:0] SEL_ONE     = SEL_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SELECT,
        S_SETTLE,
        S_COUNT,
        S_STORE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [WIN_W-1:0] win_len_q, win_len_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [SEL_W-1:0] ro_select_q, ro_select_d;
    logic             ro_en_q, ro_en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [N_RO-2:0]  response_q, response_d;
    logic [CNT_W-1:0] count_q [N_RO];
    logic [CNT_W-1:0] count_d [N_RO];

    logic sync1_q, sync2_q, sync3_q;
    logic edge_det;
    logic clear_en;
    logic store_en;
    logic cmp_en;
`ifdef PUF_MASK_EN
    logic latch_en;
`endif

    // Two-flop synchroniser followed by a delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.ro_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~sync3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            win_len_q   <= WIN_ONE;
            win_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            ro_select_q <= '0;
            ro_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            response_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            win_len_q   <= win_len_d;
            win_cnt_q   <= win_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            ro_select_q <= ro_select_d;
            ro_en_q     <= ro_en_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            response_q  <= response_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        win_len_d   = win_len_q;
        win_cnt_d   = win_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        ro_select_d = ro_select_q;
        ro_en_d     = ro_en_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        clear_en    = 1'b0;
        store_en    = 1'b0;
        cmp_en      = 1'b0;
`ifdef PUF_MASK_EN
        latch_en    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_CLEAR;
                    win_len_d = (bus.window == '0) ? WIN_ONE : bus.window;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
`ifdef PUF_MASK_EN
                    latch_en  = 1'b1;
`endif
                end
            end
            S_CLEAR: begin
                clear_en = 1'b1;
                idx_d    = '0;
                state_d  = S_SELECT;
            end
            S_SELECT: begin
                ro_select_d = idx_q;
                ro_en_d     = 1'b1;
                win_cnt_d   = '0;
                edge_cnt_d  = '0;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                // Edges seen here are synchroniser residue from the mux switch
                if (win_cnt_q == SETTLE_LAST) begin
                    win_cnt_d = '0;
                    state_d   = S_COUNT;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_ONE;
                end
            end
            S_COUNT: begin
                if (edge_det && (edge_cnt_q != '1)) begin
                    edge_cnt_d = edge_cnt_q + CNT_ONE;
                end
                if (win_cnt_q == (win_len_q - WIN_ONE)) begin
                    ro_en_d = 1'b0;
                    state_d = S_STORE;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_ONE;
                end
            end
            S_STORE: begin
                store_en = 1'b1;
                if (idx_q == LAST_RO) begin
                    idx_d   = '0;
                    state_d = S_COMPARE;
                end else begin
                    idx_d   = idx_q + SEL_ONE;
                    state_d = S_SELECT;
                end
            end
            S_COMPARE: begin
                cmp_en = 1'b1;
                if (idx_q == LAST_PAIR) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + SEL_ONE;
                end
            end
            S_DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_RO; gi++) begin : g_count
            assign count_d[gi] = clear_en ? '0 :
                                 (store_en && (idx_q == SEL_W'(gi))) ? edge_cnt_q :
                                 count_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q[gi] <= '0;
                end else begin
                    count_q[gi] <= count_d[gi];
                end
            end
        end
    endgenerate

    // One adjacent pair is evaluated per COMPARE cycle, selected by idx
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             pair_lt;

    assign cnt_a   = count_q[idx_q];
    assign cnt_b   = count_q[idx_q + SEL_ONE];
    assign pair_lt = (cnt_a < cnt_b);

    generate
        for (gi = 0; gi < N_RO - 1; gi++) begin : g_resp
            assign response_d[gi] = clear_en ? 1'b0 :
                                    (cmp_en && (idx_q == SEL_W'(gi))) ? pair_lt :
                                    response_q[gi];
        end
    endgenerate

`ifdef PUF_MASK_EN
    logic [CNT_W-1:0] margin_q, margin_d;
    logic [CNT_W:0]   diff_ab;
    logic [CNT_W:0]   diff_ba;
    logic [CNT_W:0]   abs_diff;
    logic             pair_ok;
    logic [N_RO-2:0]  mask_q, mask_d;

    assign margin_d = latch_en ? bus.margin : margin_q;
    assign diff_ab  = {1'b0, cnt_a} - {1'b0, cnt_b};
    assign diff_ba  = {1'b0, cnt_b} - {1'b0, cnt_a};
    assign abs_diff = pair_lt ? diff_ba : diff_ab;
    assign pair_ok  = (abs_diff >= {1'b0, margin_q});

    generate
        for (gi = 0; gi < N_RO - 1; gi++) begin : g_mask
            assign mask_d[gi] = clear_en ? 1'b0 :
                                (cmp_en && (idx_q == SEL_W'(gi))) ? pair_ok :
                                mask_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            margin_q <= '0;
            mask_q   <= '0;
        end else begin
            margin_q <= margin_d;
            mask_q   <= mask_d;
        end
    end

    assign bus.mask = mask_q;
`else
    assign bus.mask = '1;
`endif

    assign bus.ro_select = ro_select_q;
    assign bus.ro_en     = ro_en_q;
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.response  = response_q;

endmodule
